lc3_mmio_ctrl: RTL and testbench

//  Memory-mapped I/O controller for the LC-3 core, decoding addresses xFE00 and up.

---
 rtl/lc3_mmio_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lc3_mmio_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mmio_ctrl
// Brief    : LC-3 memory-mapped I/O controller. It decodes xFE00 and above,
//            buffers keyboard characters in a FIFO, holds one outbound display
//            character, owns the MCR run bit and produces IRQ/INTP/INTV.
// Options  : define LC3_MMIO_TIMER_EN to add the TMR/TCR interval timer.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mmio_ctrl #(
    parameter int         KBD_DEPTH = 4,
    parameter logic [2:0] KBD_PRI   = 3'd4,
    parameter logic [7:0] KBD_VEC   = 8'h80,
    parameter logic [2:0] DSP_PRI   = 3'd4,
    parameter logic [7:0] DSP_VEC   = 8'h81
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mmio_addr,
    input  logic [15:0] mmio_wdata,
    input  logic        mmio_we,
    input  logic        mmio_re,
    output logic [15:0] mmio_rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        irq,
    output logic [2:0]  intp,
    output logic [7:0]  intv,
    output logic        mcr_run
);

    localparam int          PW          = $clog2(KBD_DEPTH);
    localparam logic [PW:0] C_DEPTH     = (PW+1)'(KBD_DEPTH);
    localparam logic [15:0] C_KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] C_KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] C_DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] C_DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] C_MCR_ADDR  = 16'hFFFE;
`ifdef LC3_MMIO_TIMER_EN
    localparam logic [15:0] C_TMR_ADDR  = 16'hFE08;
    localparam logic [15:0] C_TCR_ADDR  = 16'hFE0A;
    localparam logic [2:0]  C_TMR_PRI   = 3'd2;
    localparam logic [7:0]  C_TMR_VEC   = 8'h82;
`endif

    // Keyboard FIFO storage and bookkeeping
    logic [7:0]    fifo_mem_q [KBD_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    // Control/status registers
    logic          kbd_ie_q, kbd_ie_d;
    logic          dsp_ie_q, dsp_ie_d;
    logic          ovr_q, ovr_d;
    logic          dsp_valid_q, dsp_valid_d;
    logic [7:0]    dsp_data_q, dsp_data_d;
    logic          run_q, run_d;

    // Registered interrupt outputs
    logic          irq_q, irq_d;
    logic [2:0]    intp_q, intp_d;
    logic [7:0]    intv_q, intv_d;

`ifdef LC3_MMIO_TIMER_EN
    logic [15:0]   tmr_q, tmr_d;
    logic [15:0]   tcnt_q, tcnt_d;
    logic          texp_q, texp_d;
    logic          tie_q, tie_d;
    logic          ten_q, ten_d;
    logic          w_tmr_int;
`endif

    logic w_empty, w_full, w_push, w_pop, w_ddr_wr, w_dsp_accept;
    logic w_kbd_int, w_dsp_int;
    logic w_unused_wdata;

    assign w_empty      = (count_q == '0);
    assign w_full       = (count_q == C_DEPTH);
    assign w_push       = kbd_valid && !w_full;
    assign w_pop        = mmio_re && (mmio_addr == C_KBDR_ADDR) && !w_empty;
    assign w_ddr_wr     = mmio_we && (mmio_addr == C_DDR_ADDR);
    assign w_dsp_accept = dsp_valid_q && dsp_ready;
    // DSR[15] (ready) is exactly the complement of an in-flight character.
    assign w_kbd_int    = !w_empty && kbd_ie_q;
    assign w_dsp_int    = !dsp_valid_q && dsp_ie_q;
`ifdef LC3_MMIO_TIMER_EN
    assign w_tmr_int    = texp_q && tie_q;
`endif
    // Write-data bits that no register stores in the default build.
    assign w_unused_wdata = ^mmio_wdata[13:8];

    assign kbd_ready = !w_full;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;
    assign irq       = irq_q;
    assign intp      = intp_q;
    assign intv      = intv_q;
    assign mcr_run   = run_q;

    // Next-state logic for the FIFO, registers, display handshake and interrupts.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        kbd_ie_d    = kbd_ie_q;
        dsp_ie_d    = dsp_ie_q;
        ovr_d       = ovr_q;
        dsp_valid_d = dsp_valid_q;
        dsp_data_d  = dsp_data_q;
        run_d       = run_q;
        irq_d       = irq_q;
        intp_d      = intp_q;
        intv_d      = intv_q;
`ifdef LC3_MMIO_TIMER_EN
        tmr_d       = tmr_q;
        tcnt_d      = tcnt_q;
        texp_d      = texp_q;
        tie_d       = tie_q;
        ten_d       = ten_q;
`endif

        // Pointers wrap naturally because the depth is a power of two.
        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (mmio_we) begin
            case (mmio_addr)
                C_KBSR_ADDR: kbd_ie_d = mmio_wdata[14];
                C_DSR_ADDR: begin
                    dsp_ie_d = mmio_wdata[14];
                    ovr_d    = 1'b0;
                end
                C_MCR_ADDR:  run_d = mmio_wdata[15];
`ifdef LC3_MMIO_TIMER_EN
                C_TMR_ADDR: begin
                    tmr_d  = mmio_wdata;
                    tcnt_d = mmio_wdata;
                end
                C_TCR_ADDR: begin
                    texp_d = 1'b0;
                    tie_d  = mmio_wdata[14];
                    ten_d  = mmio_wdata[13];
                end
`endif
                default: ;
            endcase
        end

        // Readiness is judged on the pre-edge state, so a DDR write landing on
        // the accept edge still sees a busy display and is dropped.
        if (w_dsp_accept) dsp_valid_d = 1'b0;
        if (w_ddr_wr) begin
            if (!dsp_valid_q) begin
                dsp_valid_d = 1'b1;
                dsp_data_d  = mmio_wdata[7:0];
            end else begin
                ovr_d = 1'b1;
            end
        end

`ifdef LC3_MMIO_TIMER_EN
        // Counting is suspended in the cycle software rewrites the interval.
        if (ten_q && (tmr_q != 16'h0000) && !(mmio_we && (mmio_addr == C_TMR_ADDR))) begin
            if (tcnt_q <= 16'd1) begin
                texp_d = 1'b1;
                tcnt_d = tmr_q;
            end else begin
                tcnt_d = tcnt_q - 16'd1;
            end
        end
`endif

        // Fixed precedence; with nothing pending the priority/vector hold.
        irq_d = w_kbd_int || w_dsp_int;
`ifdef LC3_MMIO_TIMER_EN
        irq_d = irq_d || w_tmr_int;
`endif
        if (w_kbd_int) begin
            intp_d = KBD_PRI;
            intv_d = KBD_VEC;
        end else if (w_dsp_int) begin
            intp_d = DSP_PRI;
            intv_d = DSP_VEC;
        end
`ifdef LC3_MMIO_TIMER_EN
        else if (w_tmr_int) begin
            intp_d = C_TMR_PRI;
            intv_d = C_TMR_VEC;
        end
`endif
    end

    // Control state registers; reset abandons buffered and in-flight data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            kbd_ie_q    <= 1'b0;
            dsp_ie_q    <= 1'b0;
            ovr_q       <= 1'b0;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= 8'h00;
            run_q       <= 1'b1;
            irq_q       <= 1'b0;
            intp_q      <= 3'd0;
            intv_q      <= 8'h00;
`ifdef LC3_MMIO_TIMER_EN
            tmr_q       <= 16'h0000;
            tcnt_q      <= 16'h0000;
            texp_q      <= 1'b0;
            tie_q       <= 1'b0;
            ten_q       <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            kbd_ie_q    <= kbd_ie_d;
            dsp_ie_q    <= dsp_ie_d;
            ovr_q       <= ovr_d;
            dsp_valid_q <= dsp_valid_d;
            dsp_data_q  <= dsp_data_d;
            run_q       <= run_d;
            irq_q       <= irq_d;
            intp_q      <= intp_d;
            intv_q      <= intv_d;
`ifdef LC3_MMIO_TIMER_EN
            tmr_q       <= tmr_d;
            tcnt_q      <= tcnt_d;
            texp_q      <= texp_d;
            tie_q       <= tie_d;
            ten_q       <= ten_d;
`endif
        end
    end

    // FIFO storage: plain memory, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) fifo_mem_q[wr_ptr_q] <= kbd_data;
    end

    // Combinational read mux; unmapped and write-only addresses return 0.
    always_comb begin
        mmio_rdata = 16'h0000;
        case (mmio_addr)
            C_KBSR_ADDR: mmio_rdata = {!w_empty, kbd_ie_q, 14'h0000};
            C_KBDR_ADDR: if (!w_empty) mmio_rdata = {8'h00, fifo_mem_q[rd_ptr_q]};
            C_DSR_ADDR:  mmio_rdata = {!dsp_valid_q, dsp_ie_q, 13'h0000, ovr_q};
            C_MCR_ADDR:  mmio_rdata = {run_q, 15'h0000};
`ifdef LC3_MMIO_TIMER_EN
            C_TMR_ADDR:  mmio_rdata = tmr_q;
            C_TCR_ADDR:  mmio_rdata = {texp_q, tie_q, ten_q, 13'h0000};
`endif
            default:     mmio_rdata = 16'h0000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3_mmio_ctrl
// Brief    : Self-checking bench for lc3_mmio_ctrl (default build, no timer).
//            A queue-based model predicts every output each cycle; directed
//            literal checks pin the model to hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3_mmio_ctrl;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [15:0] mmio_addr;
    logic [15:0] mmio_wdata;
    logic        mmio_we;
    logic        mmio_re;
    logic [15:0] mmio_rdata;
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;
    logic        irq;
    logic [2:0]  intp;
    logic [7:0]  intv;
    logic        mcr_run;

    lc3_mmio_ctrl #(
        .KBD_DEPTH (DEPTH),
        .KBD_PRI   (3'd4),
        .KBD_VEC   (8'h80),
        .DSP_PRI   (3'd4),
        .DSP_VEC   (8'h81)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mmio_addr  (mmio_addr),
        .mmio_wdata (mmio_wdata),
        .mmio_we    (mmio_we),
        .mmio_re    (mmio_re),
        .mmio_rdata (mmio_rdata),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .kbd_ready  (kbd_ready),
        .dsp_valid  (dsp_valid),
        .dsp_data   (dsp_data),
        .dsp_ready  (dsp_ready),
        .irq        (irq),
        .intp       (intp),
        .intv       (intv),
        .mcr_run    (mcr_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_busy, m_ovr, m_kie, m_die, m_run, m_irq;
    logic [7:0] m_char, m_intv;
    logic [2:0] m_intp;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 1'b0; m_ovr = 1'b0; m_kie = 1'b0; m_die = 1'b0;
        m_run  = 1'b1; m_irq = 1'b0; m_char = 8'h00;
        m_intp = 3'd0; m_intv = 8'h00;
    endtask

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        case (a)
            16'hFE00: return {(mq.size() > 0), m_kie, 14'h0};
            16'hFE02: return (mq.size() > 0) ? {8'h00, mq[0]} : 16'h0000;
            16'hFE04: return {!m_busy, m_die, 13'h0, m_ovr};
            16'hFFFE: return {m_run, 15'h0};
            default:  return 16'h0000;
        endcase
    endfunction

    // One clock edge of the specified behaviour, using the pre-edge state.
    task automatic model_step();
        bit kc, dc, ob;
        kc = (mq.size() > 0) && m_kie;
        dc = !m_busy && m_die;
        ob = m_busy;
        m_irq = kc || dc;
        if (kc) begin m_intp = 3'd4; m_intv = 8'h80; end
        else if (dc) begin m_intp = 3'd4; m_intv = 8'h81; end
        if (mmio_re && mmio_addr == 16'hFE02 && mq.size() > 0) begin
            if (kbd_valid && mq.size() < DEPTH) mq.push_back(kbd_data);
            void'(mq.pop_front());
        end else if (kbd_valid && mq.size() < DEPTH) begin
            mq.push_back(kbd_data);
        end
        if (mmio_we && mmio_addr == 16'hFE00) m_kie = mmio_wdata[14];
        if (mmio_we && mmio_addr == 16'hFE04) begin m_die = mmio_wdata[14]; m_ovr = 1'b0; end
        if (mmio_we && mmio_addr == 16'hFFFE) m_run = mmio_wdata[15];
        if (ob && dsp_ready) m_busy = 1'b0;
        if (mmio_we && mmio_addr == 16'hFE06) begin
            if (ob) m_ovr = 1'b1;
            else begin m_busy = 1'b1; m_char = mmio_wdata[7:0]; end
        end
    endtask

    task automatic compare_all();
        chk("rdata",     mmio_rdata,        m_rd(mmio_addr));
        chk("kbd_ready", 16'(kbd_ready),    16'(mq.size() < DEPTH));
        chk("dsp_valid", 16'(dsp_valid),    16'(m_busy));
        chk("dsp_data",  16'(dsp_data),     16'(m_char));
        chk("irq",       16'(irq),          16'(m_irq));
        chk("intp",      16'(intp),         16'(m_intp));
        chk("intv",      16'(intv),         16'(m_intv));
        chk("mcr_run",   16'(mcr_run),      16'(m_run));
    endtask

    // Advance one cycle: model follows the edge, outputs checked at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        mmio_addr = a; mmio_wdata = d; mmio_we = 1'b1;
        tick();
        mmio_we = 1'b0;
    endtask

    task automatic peek(input string n, input logic [15:0] a, input logic [15:0] e);
        mmio_addr = a; mmio_re = 1'b0;
        #1;
        chk(n, mmio_rdata, e);
    endtask

    task automatic pop_rd(input string n, input logic [15:0] e);
        mmio_addr = 16'hFE02; mmio_re = 1'b1;
        #1;
        chk(n, mmio_rdata, e);
        tick();
        mmio_re = 1'b0;
    endtask

    task automatic push(input logic [7:0] c);
        kbd_valid = 1'b1; kbd_data = c;
        tick();
        kbd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mmio_addr = 16'h0000; mmio_wdata = 16'h0000;
        mmio_we = 1'b0; mmio_re = 1'b0; kbd_valid = 1'b0; kbd_data = 8'h00;
        dsp_ready = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;

        // Reset state
        peek("rst_kbsr", 16'hFE00, 16'h0000);
        peek("rst_dsr",  16'hFE04, 16'h8000);
        peek("rst_mcr",  16'hFFFE, 16'h8000);
        chk("rst_irq", 16'(irq), 16'h0000);
        chk("rst_kbd_ready", 16'(kbd_ready), 16'h0001);

        // Two characters in, read out in order, then empty
        push(8'h41); push(8'h42);
        peek("kbsr_ne", 16'hFE00, 16'h8000);
        pop_rd("kbdr_A", 16'h0041);
        pop_rd("kbdr_B", 16'h0042);
        pop_rd("kbdr_empty", 16'h0000);
        peek("kbsr_empty", 16'hFE00, 16'h0000);

        // Overfill: fifth character held off until space frees
        kbd_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            kbd_data = 8'h30 + 8'(i);
            tick();
        end
        chk("full_ready", 16'(kbd_ready), 16'h0000);
        kbd_data = 8'h34;
        tick(); tick();
        chk("full_held", 16'(kbd_ready), 16'h0000);
        pop_rd("ovf_0", 16'h0030);
        tick();
        kbd_valid = 1'b0;
        pop_rd("ovf_1", 16'h0031);
        pop_rd("ovf_2", 16'h0032);
        pop_rd("ovf_3", 16'h0033);
        pop_rd("ovf_4", 16'h0034);
        pop_rd("ovf_empty", 16'h0000);
        chk("drained_ready", 16'(kbd_ready), 16'h0001);

        // Display path, overrun and accept
        dsp_ready = 1'b0;
        wr(16'hFE06, 16'h0048);
        peek("dsr_busy", 16'hFE04, 16'h0000);
        chk("dsp_valid_1", 16'(dsp_valid), 16'h0001);
        chk("dsp_data_48", 16'(dsp_data), 16'h0048);
        wr(16'hFE06, 16'h0055);
        peek("dsr_ovr", 16'hFE04, 16'h0001);
        chk("dsp_data_hold", 16'(dsp_data), 16'h0048);
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
        peek("dsr_ready", 16'hFE04, 16'h8001);
        chk("dsp_valid_0", 16'(dsp_valid), 16'h0000);
        wr(16'hFE04, 16'h0000);
        peek("dsr_ovr_clr", 16'hFE04, 16'h8000);
        // DDR write on the accept edge is dropped
        wr(16'hFE06, 16'h0011);
        dsp_ready = 1'b1; mmio_addr = 16'hFE06; mmio_wdata = 16'h0022; mmio_we = 1'b1;
        tick();
        mmio_we = 1'b0; dsp_ready = 1'b0;
        peek("coincide_dsr", 16'hFE04, 16'h8001);
        chk("coincide_valid", 16'(dsp_valid), 16'h0000);
        chk("coincide_data", 16'(dsp_data), 16'h0011);
        wr(16'hFE04, 16'h0000);

        // Interrupts: display first, keyboard takes over, display returns
        wr(16'hFE00, 16'h4000);
        wr(16'hFE04, 16'h4000);
        chk("irq_latency", 16'(irq), 16'h0000);
        push(8'h65);
        chk("irq_dsp", 16'(irq), 16'h0001);
        chk("intv_dsp", 16'(intv), 16'h0081);
        tick();
        chk("intp_kbd", 16'(intp), 16'h0004);
        chk("intv_kbd", 16'(intv), 16'h0080);
        pop_rd("irq_char", 16'h0065);
        tick();
        chk("intv_back", 16'(intv), 16'h0081);
        chk("irq_still", 16'(irq), 16'h0001);
        wr(16'hFE04, 16'h0000);
        wr(16'hFE00, 16'h0000);
        chk("irq_off", 16'(irq), 16'h0000);
        chk("intv_hold", 16'(intv), 16'h0081);

        // MCR and unmapped addresses
        wr(16'hFFFE, 16'h0000);
        chk("mcr_clr", 16'(mcr_run), 16'h0000);
        peek("mcr_rd", 16'hFFFE, 16'h0000);
        wr(16'hFE10, 16'hFFFF);
        peek("unmapped", 16'hFE10, 16'h0000);
        peek("ddr_rd", 16'hFE06, 16'h0000);
        peek("tmr_absent", 16'hFE08, 16'h0000);

        // Simultaneous push and pop with two entries
        push(8'h61); push(8'h62);
        kbd_valid = 1'b1; kbd_data = 8'h63; mmio_addr = 16'hFE02; mmio_re = 1'b1;
        #1;
        chk("pp_head", mmio_rdata, 16'h0061);
        tick();
        kbd_valid = 1'b0; mmio_re = 1'b0;
        peek("pp_peek", 16'hFE02, 16'h0062);
        pop_rd("pp_1", 16'h0062);
        pop_rd("pp_2", 16'h0063);
        pop_rd("pp_empty", 16'h0000);

        // Asynchronous reset in the middle of a display transfer
        push(8'h7A);
        wr(16'hFE06, 16'h005A);
        chk("pre_rst_valid", 16'(dsp_valid), 16'h0001);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 16'(dsp_valid), 16'h0000);
        chk("rst_async_run", 16'(mcr_run), 16'h0001);
        model_reset();
        tick();
        rst = 1'b0;
        peek("post_rst_kbsr", 16'hFE00, 16'h0000);
        peek("post_rst_dsr", 16'hFE04, 16'h8000);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
